// File: rtl/rtc_bus_sequencer_if.sv
// Request/response handshake between the RTC control FSM and the bus sequencer.
// The controller side uses the master modport; the sequencer uses slave.
interface rtc_bus_sequencer_if;
    logic       start;
    logic       is_write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (
        output start, is_write, addr, wdata,
        input  ready, busy, done, rdata
    );

    modport slave (
        input  start, is_write, addr, wdata,
        output ready, busy, done, rdata
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Sequences one complete read or write transaction on the RTC chip's
// multiplexed address/data bus (CS, AD, WR, RD, DatAdd). The address half and
// the data half are each built from setup / strobe / release phases, separated
// by a CS-high gap. A single down-counter times every state.
// Optional feature: define RTC_BUS_QUEUE_EN to add a one-entry request holding
// register that allows back-to-back transactions without an idle cycle.
module rtc_bus_sequencer #(
    parameter int unsigned PHASE_CYC = 8,   // cycles per bus phase, 1..255
    parameter int unsigned GAP_CYC   = 4    // CS-high cycles between halves, 1..255
) (
    input  logic               clk,
    input  logic               reset,       // asynchronous, active low
    rtc_bus_sequencer_if.slave req,
    output logic               cs_n,
    output logic               ad,
    output logic               wr_n,
    output logic               rd_n,
    output logic [7:0]         dat_out,
    output logic               dat_oe,
    input  logic [7:0]         dat_in
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SET,
        S_A_STB,
        S_A_REL,
        S_TURN,
        S_D_SET,
        S_D_STB,
        S_D_REL,
        S_DONE
    } state_t;

    // Counter reload values: a state lasts (reload + 1) cycles.
    localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phase_end;

    logic       ready_int;
    logic       launch_en;
    logic       src_valid;
    logic       launch;

    // Request fields that the next launched transaction will use.
    logic       nxt_write;
    logic [7:0] nxt_addr;
    logic [7:0] nxt_wdata;

    // Request fields of the transaction currently on the bus.
    logic       req_write_q;
    logic [7:0] req_addr_q;
    logic [7:0] req_wdata_q;

    logic [7:0] rdata_q;

    assign phase_end = (cnt_q == 8'd0);

`ifdef RTC_BUS_QUEUE_EN
    logic       slot_valid_q;
    logic       slot_write_q;
    logic [7:0] slot_addr_q;
    logic [7:0] slot_wdata_q;

    // A new request can be taken whenever the holding slot is free; a launch
    // may happen from IDLE or straight out of DONE.
    assign ready_int = !slot_valid_q;
    assign launch_en = (state_q == S_IDLE) || (state_q == S_DONE);
    assign src_valid = slot_valid_q || (req.start && ready_int);

    // The queued request has priority over a request arriving this cycle
    // (the two cannot coexist: ready is low while the slot is full).
    always_comb begin
        if (slot_valid_q) begin
            nxt_write = slot_write_q;
            nxt_addr  = slot_addr_q;
            nxt_wdata = slot_wdata_q;
        end else begin
            nxt_write = req.is_write;
            nxt_addr  = req.addr;
            nxt_wdata = req.wdata;
        end
    end

    // Holding slot: filled by a request that cannot launch immediately,
    // emptied when its transaction launches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid_q <= 1'b0;
            slot_write_q <= 1'b0;
            slot_addr_q  <= 8'h00;
            slot_wdata_q <= 8'h00;
        end else if (launch && slot_valid_q) begin
            slot_valid_q <= 1'b0;
        end else if (req.start && ready_int && !launch) begin
            slot_valid_q <= 1'b1;
            slot_write_q <= req.is_write;
            slot_addr_q  <= req.addr;
            slot_wdata_q <= req.wdata;
        end
    end
`else
    // Without the holding register a request is only taken in IDLE; anything
    // presented while busy is dropped.
    assign ready_int = (state_q == S_IDLE);
    assign launch_en = (state_q == S_IDLE);
    assign src_valid = req.start && ready_int;
    assign nxt_write = req.is_write;
    assign nxt_addr  = req.addr;
    assign nxt_wdata = req.wdata;
`endif

    assign launch = launch_en && src_valid;

    // State and phase counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: each state counts down and advances when the counter hits
    // zero, reloading the counter with the next state's length minus one.
    always_comb begin
        // NOTE: defaults first so every path assigns every output of this
        // block; a missing branch would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = phase_end ? cnt_q : cnt_q - 8'd1;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_A_SET;
                    cnt_d   = PHASE_LAST;
                end
            end
            S_A_SET: if (phase_end) begin state_d = S_A_STB; cnt_d = PHASE_LAST; end
            S_A_STB: if (phase_end) begin state_d = S_A_REL; cnt_d = PHASE_LAST; end
            S_A_REL: if (phase_end) begin state_d = S_TURN;  cnt_d = GAP_LAST;   end
            S_TURN:  if (phase_end) begin state_d = S_D_SET; cnt_d = PHASE_LAST; end
            S_D_SET: if (phase_end) begin state_d = S_D_STB; cnt_d = PHASE_LAST; end
            S_D_STB: if (phase_end) begin state_d = S_D_REL; cnt_d = PHASE_LAST; end
            S_D_REL: if (phase_end) begin state_d = S_DONE;  cnt_d = 8'h00;      end
            S_DONE: begin
                if (launch) begin
                    state_d = S_A_SET;
                    cnt_d   = PHASE_LAST;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 8'h00;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'h00;
            end
        endcase
    end

    // Capture the launched request so later input changes have no effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_write_q <= 1'b0;
            req_addr_q  <= 8'h00;
            req_wdata_q <= 8'h00;
        end else if (launch) begin
            req_write_q <= nxt_write;
            req_addr_q  <= nxt_addr;
            req_wdata_q <= nxt_wdata;
        end
    end

    // Read data is sampled on the last cycle of the read strobe only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 8'h00;
        end else if (state_q == S_D_STB && phase_end && !req_write_q) begin
            rdata_q <= dat_in;
        end
    end

    // Pin decode from the registered state; reset forces IDLE, which releases
    // the bus in the same cycle.
    always_comb begin
        cs_n    = 1'b1;
        ad      = 1'b1;
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        dat_oe  = 1'b0;
        dat_out = 8'h00;
        case (state_q)
            S_A_SET, S_A_REL: begin
                cs_n    = 1'b0;
                ad      = 1'b0;
                dat_oe  = 1'b1;
                dat_out = req_addr_q;
            end
            S_A_STB: begin
                cs_n    = 1'b0;
                ad      = 1'b0;
                wr_n    = 1'b0;
                dat_oe  = 1'b1;
                dat_out = req_addr_q;
            end
            S_TURN: begin
                dat_oe  = req_write_q;
                dat_out = req_write_q ? req_wdata_q : 8'h00;
            end
            S_D_SET, S_D_REL: begin
                cs_n    = 1'b0;
                dat_oe  = req_write_q;
                dat_out = req_write_q ? req_wdata_q : 8'h00;
            end
            S_D_STB: begin
                cs_n    = 1'b0;
                wr_n    = !req_write_q;
                rd_n    = req_write_q;
                dat_oe  = req_write_q;
                dat_out = req_write_q ? req_wdata_q : 8'h00;
            end
            default: ;
        endcase
    end

    assign req.ready = ready_int;
    assign req.busy  = (state_q != S_IDLE);
    assign req.done  = (state_q == S_DONE);
    assign req.rdata = rdata_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed self-checking bench for rtc_bus_sequencer. Drives and samples on the
// falling clock edge; cycle k is the k-th falling edge after the one on which
// start was presented. A second instance runs with 1-cycle phases.
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_bus_sequencer_if bus ();
    rtc_bus_sequencer_if fbus ();

    logic       cs_n, ad, wr_n, rd_n, dat_oe;
    logic [7:0] dat_out, dat_in;
    logic       fcs_n, fad, fwr_n, frd_n, fdat_oe;
    logic [7:0] fdat_out, fdat_in;

    rtc_bus_sequencer #(.PHASE_CYC(8), .GAP_CYC(4)) dut (
        .clk(clk), .reset(reset), .req(bus.slave),
        .cs_n(cs_n), .ad(ad), .wr_n(wr_n), .rd_n(rd_n),
        .dat_out(dat_out), .dat_oe(dat_oe), .dat_in(dat_in)
    );

    rtc_bus_sequencer #(.PHASE_CYC(1), .GAP_CYC(1)) dut_fast (
        .clk(clk), .reset(reset), .req(fbus.slave),
        .cs_n(fcs_n), .ad(fad), .wr_n(fwr_n), .rd_n(frd_n),
        .dat_out(fdat_out), .dat_oe(fdat_oe), .dat_in(fdat_in)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Statistics gathered by watch().
    int   done_cnt, done1, done2;
    int   a_wr_low, a_bad, d_wr_low, d_bad, d_rd_low, rd_oe, both_low, oe_ad1;
    logic busy_c1, aset_after_d1, ready_after_d1, ready_after_inj1;

    // Runs max_cyc cycles watching the main instance. A request must already be
    // presented (or not) before the call; up to two more are injected at cycles
    // inj1/inj2 (0 = none). Expected address/data switch to request 1 after the
    // first done pulse.
    task automatic watch(input int max_cyc, input logic [7:0] din,
                         input logic [7:0] exp_a0, input logic [7:0] exp_d0,
                         input int inj1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                         input int inj2, input logic w2, input logic [7:0] a2, input logic [7:0] d2);
        logic [7:0] ea, ed;
        ea = exp_a0; ed = exp_d0;
        done_cnt = 0; done1 = 0; done2 = 0;
        a_wr_low = 0; a_bad = 0; d_wr_low = 0; d_bad = 0; d_rd_low = 0;
        rd_oe = 0; both_low = 0; oe_ad1 = 0;
        busy_c1 = 1'b0; aset_after_d1 = 1'b0; ready_after_d1 = 1'b0; ready_after_inj1 = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (k == 1) busy_c1 = bus.busy;
            if (done_cnt >= 1 && k == done1 + 1) begin
                aset_after_d1  = !cs_n && !ad;
                ready_after_d1 = bus.ready;
            end
            if (inj1 > 0 && k == inj1 + 1) ready_after_inj1 = bus.ready;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin done1 = k; ea = a1; ed = d1; end
                else if (done_cnt == 2) done2 = k;
            end
            if (!wr_n && !ad) begin
                a_wr_low++;
                if (dat_out !== ea || dat_oe !== 1'b1) a_bad++;
            end
            if (!wr_n && ad) begin
                d_wr_low++;
                if (dat_out !== ed || dat_oe !== 1'b1) d_bad++;
            end
            if (!rd_n) d_rd_low++;
            if (!rd_n && dat_oe) rd_oe++;
            if (!wr_n && !rd_n) both_low++;
            if (ad && dat_oe) oe_ad1++;
            // Pad shows the read value only while RD is low.
            dat_in = !rd_n ? din : 8'hAA;
            if (k == inj1) begin
                bus.start = 1'b1; bus.is_write = w1; bus.addr = a1; bus.wdata = d1;
            end else if (k == inj2) begin
                bus.start = 1'b1; bus.is_write = w2; bus.addr = a2; bus.wdata = d2;
            end else begin
                bus.start = 1'b0;
                if (k == 1) begin
                    // Disturb the request fields after acceptance.
                    bus.is_write = !bus.is_write; bus.addr = 8'hE7; bus.wdata = 8'h7E;
                end
            end
        end
    endtask

    int   fd, fdone_cnt, fa_wr, fd_wr, fd_rd, fd_bad;
    logic found;

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.is_write = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
        fbus.start = 1'b0; fbus.is_write = 1'b0; fbus.addr = 8'h00; fbus.wdata = 8'h00;
        dat_in = 8'h00; fdat_in = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_ad", ad, 1'b1);
        check("rst_wr_n", wr_n, 1'b1);
        check("rst_rd_n", rd_n, 1'b1);
        check("rst_dat_oe", dat_oe, 1'b0);
        check("rst_dat_out", dat_out, 8'h00);
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_done", bus.done, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.ready, 1'b1);

        // Write 0x15 to 0x21.
        bus.start = 1'b1; bus.is_write = 1'b1; bus.addr = 8'h21; bus.wdata = 8'h15;
        watch(60, 8'h00, 8'h21, 8'h15, 0, 1'b0, 8'h21, 8'h15, 0, 1'b0, 8'h00, 8'h00);
        check("wr_busy_c1", busy_c1, 1'b1);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_done_cycle", done1, 53);
        check("wr_addr_strobe_len", a_wr_low, 8);
        check("wr_addr_value", a_bad, 0);
        check("wr_data_strobe_len", d_wr_low, 8);
        check("wr_data_value", d_bad, 0);
        check("wr_no_rd", d_rd_low, 0);
        check("wr_rdata_kept", bus.rdata, 8'h00);
        check("wr_end_busy", bus.busy, 1'b0);
        check("wr_end_ready", bus.ready, 1'b1);

        // Read 0x22, pad returns 0x37.
        bus.start = 1'b1; bus.is_write = 1'b0; bus.addr = 8'h22; bus.wdata = 8'h00;
        watch(60, 8'h37, 8'h22, 8'h00, 0, 1'b0, 8'h22, 8'h00, 0, 1'b0, 8'h00, 8'h00);
        check("rd_done_cycle", done1, 53);
        check("rd_addr_strobe_len", a_wr_low, 8);
        check("rd_addr_value", a_bad, 0);
        check("rd_strobe_len", d_rd_low, 8);
        check("rd_no_data_wr", d_wr_low, 0);
        check("rd_oe_while_rd", rd_oe, 0);
        check("rd_oe_data_half", oe_ad1, 0);
        check("rd_both_low", both_low, 0);
        check("rd_rdata", bus.rdata, 8'h37);

`ifdef RTC_BUS_QUEUE_EN
        // Write, read queued at cycle 10, third request at cycle 20 dropped.
        bus.start = 1'b1; bus.is_write = 1'b1; bus.addr = 8'h40; bus.wdata = 8'h99;
        watch(200, 8'h5A, 8'h40, 8'h99, 10, 1'b0, 8'h41, 8'h00, 20, 1'b1, 8'h77, 8'h11);
        check("q_ready_slot_full", ready_after_inj1, 1'b0);
        check("q_done_cnt", done_cnt, 2);
        check("q_done1_cycle", done1, 53);
        check("q_done2_cycle", done2, 106);
        check("q_aset_after_done", aset_after_d1, 1'b1);
        check("q_ready_after_done", ready_after_d1, 1'b1);
        check("q_addr_strobes", a_wr_low, 16);
        check("q_addr_values", a_bad, 0);
        check("q_data_wr_strobe", d_wr_low, 8);
        check("q_data_wr_value", d_bad, 0);
        check("q_rd_strobe", d_rd_low, 8);
        check("q_rdata", bus.rdata, 8'h5A);
`else
        // Write, second request at cycle 10 is ignored.
        bus.start = 1'b1; bus.is_write = 1'b1; bus.addr = 8'h40; bus.wdata = 8'h99;
        watch(130, 8'h5A, 8'h40, 8'h99, 10, 1'b0, 8'h41, 8'h00, 0, 1'b0, 8'h00, 8'h00);
        check("nq_ready_busy", ready_after_inj1, 1'b0);
        check("nq_done_cnt", done_cnt, 1);
        check("nq_done_cycle", done1, 53);
        check("nq_addr_strobes", a_wr_low, 8);
        check("nq_data_wr_strobe", d_wr_low, 8);
        check("nq_data_wr_value", d_bad, 0);
        check("nq_no_read", d_rd_low, 0);
        check("nq_rdata_kept", bus.rdata, 8'h37);
`endif

        // One-cycle phases: write 0xC3 to 0x3C.
        fbus.start = 1'b1; fbus.is_write = 1'b1; fbus.addr = 8'h3C; fbus.wdata = 8'hC3;
        fd = 0; fdone_cnt = 0; fa_wr = 0; fd_wr = 0; fd_rd = 0; fd_bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (fbus.done) begin
                fdone_cnt++;
                if (fd == 0) fd = k;
            end
            if (!fwr_n && !fad && fdat_out !== 8'h3C) fd_bad++;
            if (!fwr_n && fad && fdat_out !== 8'hC3) fd_bad++;
            if (!fwr_n && !fad) fa_wr++;
            if (!fwr_n && fad) fd_wr++;
            if (!frd_n) fd_rd++;
            fbus.start = 1'b0;
        end
        check("fast_done_cycle", fd, 8);
        check("fast_done_cnt", fdone_cnt, 1);
        check("fast_addr_strobe", fa_wr, 1);
        check("fast_data_strobe", fd_wr, 1);
        check("fast_values", fd_bad, 0);
        check("fast_no_rd", fd_rd, 0);
        check("fast_rdata", fbus.rdata, 8'h00);
        check("fast_end_cs_n", fcs_n, 1'b1);
        check("fast_end_oe", fdat_oe, 1'b0);

        // Reset in the middle of a read strobe.
        bus.start = 1'b1; bus.is_write = 1'b0; bus.addr = 8'h22; bus.wdata = 8'h00;
        found = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            dat_in = !rd_n ? 8'h37 : 8'hAA;
            if (!rd_n) begin
                found = 1'b1;
                break;
            end
        end
        check("rr_reached_dstb", found, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rr_cs_n", cs_n, 1'b1);
        check("rr_wr_n", wr_n, 1'b1);
        check("rr_rd_n", rd_n, 1'b1);
        check("rr_dat_oe", dat_oe, 1'b0);
        check("rr_busy", bus.busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        watch(70, 8'h37, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 8'h00, 8'h00);
        check("rr_no_done", done_cnt, 0);
        check("rr_ready", bus.ready, 1'b1);
        check("rr_idle_busy", bus.busy, 1'b0);
        check("rr_rdata_cleared", bus.rdata, 8'h00);
        check("rr_idle_cs_n", cs_n, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
